// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU operation sequencer: widths, ALU op codes, FSM encoding.
package alu_seq_pkg;

  localparam int DW   = 4;
  localparam int NREG = 4;
  localparam int AW   = $clog2(NREG);

  typedef logic [DW-1:0] data_t;
  typedef logic [AW-1:0] addr_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;

endpackage

// File: rtl/alu_seq_regfile.sv
// NREG x DW register file: two write ports (writeback beats load on the same
// address) and three combinational read ports.
module alu_seq_regfile
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic [AW-1:0] rs1_addr,
  output logic [DW-1:0] rs1_data,
  input  logic [AW-1:0] rs2_addr,
  output logic [DW-1:0] rs2_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  data_t regs_q [NREG];
  data_t regs_d [NREG];

  // NOTE: the load is applied first so a writeback to the same address overwrites it.
  always_comb begin
    regs_d = regs_q;
    if (ld_en) regs_d[ld_addr] = ld_data;
    if (wb_en) regs_d[wb_addr] = wb_data;
  end

  // NOTE: the file is small and must read back as zero after reset, so every entry is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rs1_data = regs_q[rs1_addr];
  assign rs2_data = regs_q[rs2_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: IDLE -> ISSUE -> WB, writing C back to the file.
// Optional ALU_SEQ_ZERO_FLAG_EN adds a registered zero flag updated at writeback.
module alu_op_sequencer
  import alu_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [1:0]    req_rd,
  input  logic [1:0]    req_rs1,
  input  logic [1:0]    req_rs2,
  input  logic          ld_en,
  input  logic [1:0]    ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic [1:0]    alu_s,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_c,
  input  logic          alu_co,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          carry,
  input  logic [1:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
`ifdef ALU_SEQ_ZERO_FLAG_EN
  ,
  output logic          zero
`endif
);

  logic [1:0] state_q, state_d;
  logic [1:0] alu_s_q, alu_s_d;
  logic [1:0] rd_q, rd_d;
  data_t      alu_a_q, alu_a_d;
  data_t      alu_b_q, alu_b_d;
  data_t      result_q, result_d;
  logic       carry_q, carry_d;
  data_t      rs1_data, rs2_data;
  logic       wb_en;

  assign wb_en = (state_q == ST_ISSUE);

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    alu_s_d  = alu_s_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    rd_d     = rd_q;
    result_d = result_q;
    carry_d  = carry_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = ST_ISSUE;
          alu_s_d = req_op;
          alu_a_d = rs1_data;
          alu_b_d = rs2_data;
          rd_d    = req_rd;
        end
      end
      ST_ISSUE: begin
        state_d  = ST_WB;
        result_d = alu_c;
        carry_d  = alu_co;
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      alu_s_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      rd_q     <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_s_q  <= alu_s_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if (wb_en) zero_d = (alu_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_q <= 1'b1;
    else        zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

  alu_seq_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (alu_c),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .rs1_addr (req_rs1),
    .rs1_data (rs1_data),
    .rs2_addr (req_rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign done      = (state_q == ST_WB);
  assign alu_s     = alu_s_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign result    = result_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 4-bit ALU on the far side.
module tb_alu_op_sequencer;
  import alu_seq_pkg::*;

  logic       clk, rst_n;
  logic       req_valid, req_ready;
  logic [1:0] req_op, req_rd, req_rs1, req_rs2;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [3:0] ld_data;
  logic [1:0] alu_s;
  logic [3:0] alu_a, alu_b, alu_c;
  logic       alu_co;
  logic       done;
  logic [3:0] result;
  logic       carry;
  logic [1:0] dbg_addr;
  logic [3:0] dbg_data;
`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic       zero;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  alu_op_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_rd    (req_rd),
    .req_rs1   (req_rs1),
    .req_rs2   (req_rs2),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .alu_s     (alu_s),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_co    (alu_co),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
`ifdef ALU_SEQ_ZERO_FLAG_EN
    ,
    .zero      (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU: SUB is A + ~B + 1, so Co=1 means no borrow.
  always_comb begin
    logic [4:0] sum;
    sum = 5'd0;
    case (alu_s)
      OP_ADD:  sum = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'd1;
      OP_AND:  sum = {1'b0, alu_a & alu_b};
      default: sum = {1'b0, alu_a | alu_b};
    endcase
    alu_c  = sum[3:0];
    alu_co = sum[4];
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {3'b000, act}, {3'b000, exp});
  endtask

  task automatic read_reg(input logic [1:0] addr, output logic [3:0] data);
    dbg_addr = addr;
    #1;
    data = dbg_data;
  endtask

  task automatic load(input logic [1:0] addr, input logic [3:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Returns at the negedge inside ISSUE, with req_valid already dropped.
  task automatic accept(input logic [1:0] op, rd, rs1, rs2);
    int n = 0;
    req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
    req_valid = 1'b1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_bit("accept_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_c;
    logic       exp_co;
  } vec_t;

  vec_t vecs [7];
  logic [3:0] rv;
  int acc_at [$];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{OP_ADD, 4'h7, 4'h9, 4'h0, 1'b1};
    vecs[1] = '{OP_ADD, 4'h3, 4'h4, 4'h7, 1'b0};
    vecs[2] = '{OP_SUB, 4'h3, 4'h5, 4'hE, 1'b0};
    vecs[3] = '{OP_SUB, 4'h5, 4'h3, 4'h2, 1'b1};
    vecs[4] = '{OP_SUB, 4'h0, 4'h0, 4'h0, 1'b1};
    vecs[5] = '{OP_AND, 4'hA, 4'h6, 4'h2, 1'b0};
    vecs[6] = '{OP_OR,  4'hA, 4'h5, 4'hF, 1'b0};

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), rv);
      check($sformatf("reset_r%0d", i), rv, 4'h0);
    end
    check_bit("reset_ready", req_ready, 1'b1);
    check_bit("reset_done", done, 1'b0);
    check_bit("reset_carry", carry, 1'b0);
    check("reset_result", result, 4'h0);
    check({"reset_alu_s"}, {2'b00, alu_s}, 4'h0);
    check("reset_alu_a", alu_a, 4'h0);
    check("reset_alu_b", alu_b, 4'h0);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    check_bit("reset_zero", zero, 1'b1);
`endif

    // Table: r0=a, r1=b, op rd=2 rs1=0 rs2=1
    for (int i = 0; i < 7; i++) begin
      load(2'd0, vecs[i].a);
      load(2'd1, vecs[i].b);
      accept(vecs[i].op, 2'd2, 2'd0, 2'd1);
      check($sformatf("v%0d_issue_s", i), {2'b00, alu_s}, {2'b00, vecs[i].op});
      check($sformatf("v%0d_issue_a", i), alu_a, vecs[i].a);
      check($sformatf("v%0d_issue_b", i), alu_b, vecs[i].b);
      check_bit($sformatf("v%0d_issue_done", i), done, 1'b0);
      check_bit($sformatf("v%0d_issue_ready", i), req_ready, 1'b0);
      @(negedge clk);
      check_bit($sformatf("v%0d_wb_done", i), done, 1'b1);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_c);
      check_bit($sformatf("v%0d_carry", i), carry, vecs[i].exp_co);
      read_reg(2'd2, rv);
      check($sformatf("v%0d_r2", i), rv, vecs[i].exp_c);
`ifdef ALU_SEQ_ZERO_FLAG_EN
      check_bit($sformatf("v%0d_zero", i), zero, vecs[i].exp_c == 4'h0);
`endif
      @(negedge clk);
      check_bit($sformatf("v%0d_idle_done", i), done, 1'b0);
      check_bit($sformatf("v%0d_idle_ready", i), req_ready, 1'b1);
    end

    // SUB then AND chained through r3
    load(2'd0, 4'h3);
    load(2'd1, 4'h5);
    accept(OP_SUB, 2'd3, 2'd0, 2'd1);
    repeat (2) @(negedge clk);
    read_reg(2'd3, rv);
    check("chain_sub_r3", rv, 4'hE);
    check_bit("chain_sub_carry", carry, 1'b0);
    accept(OP_AND, 2'd1, 2'd3, 2'd1);
    repeat (2) @(negedge clk);
    read_reg(2'd1, rv);
    check("chain_and_r1", rv, 4'h4);
    check_bit("chain_and_carry", carry, 1'b0);

    // Load on the writeback edge to the same address: writeback wins
    load(2'd0, 4'hA);
    accept(OP_OR, 2'd0, 2'd0, 2'd0);
    ld_en = 1'b1; ld_addr = 2'd0; ld_data = 4'h5;
    @(negedge clk);
    ld_en = 1'b0;
    check_bit("coll_done", done, 1'b1);
    read_reg(2'd0, rv);
    check("coll_r0", rv, 4'hA);
    @(negedge clk);

    // Load to a different address on the writeback edge: both land
    accept(OP_OR, 2'd0, 2'd0, 2'd0);
    ld_en = 1'b1; ld_addr = 2'd3; ld_data = 4'h7;
    @(negedge clk);
    ld_en = 1'b0;
    read_reg(2'd0, rv);
    check("both_r0", rv, 4'hA);
    read_reg(2'd3, rv);
    check("both_r3", rv, 4'h7);
    @(negedge clk);

    // req_valid held high: acceptances every 3 cycles
    req_op = OP_OR; req_rd = 2'd0; req_rs1 = 2'd0; req_rs2 = 2'd0;
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (req_ready) acc_at.push_back(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_count", 4'(acc_at.size()), 4'd4);
    for (int k = 1; k < acc_at.size(); k++)
      check($sformatf("b2b_gap%0d", k), 4'(acc_at[k] - acc_at[k-1]), 4'd3);
    repeat (3) @(negedge clk);

    // Reset during ISSUE aborts the operation
    load(2'd1, 4'h1);
    load(2'd2, 4'hF);
    accept(OP_ADD, 2'd2, 2'd1, 2'd1);
    rst_n = 1'b0;
    #1;
    check_bit("rst_mid_done", done, 1'b0);
    check("rst_mid_alu_a", alu_a, 4'h0);
    @(negedge clk);
    check_bit("rst_hold_done", done, 1'b0);
    rst_n = 1'b1;
    #1;
    check_bit("rst_rel_ready", req_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      read_reg(2'(i), rv);
      check($sformatf("rst_rel_r%0d", i), rv, 4'h0);
    end
    @(negedge clk);
    check_bit("rst_after_done", done, 1'b0);
    read_reg(2'd2, rv);
    check("rst_after_r2", rv, 4'h0);
    check_bit("rst_after_carry", carry, 1'b0);

    // Load in the acceptance cycle is not seen by operand sampling
    load(2'd1, 4'h2);
    ld_en = 1'b1; ld_addr = 2'd1; ld_data = 4'h6;
    accept(OP_ADD, 2'd2, 2'd1, 2'd1);
    ld_en = 1'b0;
    check("samp_alu_a", alu_a, 4'h2);
    check("samp_alu_b", alu_b, 4'h2);
    @(negedge clk);
    check_bit("samp_done", done, 1'b1);
    read_reg(2'd2, rv);
    check("samp_r2", rv, 4'h4);
    read_reg(2'd1, rv);
    check("samp_r1", rv, 4'h6);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Drives the team's 4-bit combinational ALU from the other side of its interface.
- Holds a 4-entry x 4-bit register file and accepts one operation at a time through a valid/ready handshake.
- For each operation it presents S/A/B to the ALU, captures C/Co, and writes the result back to the register file.
- Sits between the board-level input logic (switches/buttons) and the ALU.

Parameters:
- DW, 4, operand/result width; must match the ALU width.
- NREG, 4, number of registers in the file; address width is log2(NREG) = 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  operation request.
- req_ready  output  1  block can accept a request (IDLE only).
- req_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR; same encoding as ALU S.
- req_rd  input  2  destination register.
- req_rs1  input  2  source register for ALU A.
- req_rs2  input  2  source register for ALU B.
- ld_en  input  1  direct register load strobe.
- ld_addr  input  2  load address.
- ld_data  input  DW  load data.
- alu_s  output  2  to ALU S.
- alu_a  output  DW  to ALU A.
- alu_b  output  DW  to ALU B.
- alu_c  input  DW  from ALU C.
- alu_co  input  1  from ALU Co.
- done  output  1  one-cycle pulse: result written.
- result  output  DW  last written result.
- carry  output  1  last captured Co.
- dbg_addr  input  2  debug read address.
- dbg_data  output  DW  combinational read of regfile[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=IDLE, req_ready=1, alu_s/alu_a/alu_b=0, done=0, result=0, carry=0.
  - All registers = 0.
  - Reset mid-operation aborts: no writeback, no done pulse.
- FSM states: IDLE, ISSUE, WB.
- IDLE:
  - req_ready=1.
  - Acceptance = req_valid & req_ready.
  - On acceptance: latch req_op, req_rd; load alu_s=req_op, alu_a=reg[rs1], alu_b=reg[rs2] (registered); go to ISSUE.
- ISSUE (one cycle):
  - req_ready=0; alu_* are stable.
  - At the end of the cycle: reg[rd]<=alu_c, result<=alu_c, carry<=alu_co; go to WB.
- WB (one cycle):
  - done=1; go to IDLE.
  - req_ready=0 in WB, so back-to-back requests are accepted at most every 3 cycles.
- Latency: acceptance in cycle N -> writeback on the edge ending N+1 -> done high in N+2.
- Operand sampling: operands are read at acceptance. A ld_en write in the same cycle to rs1/rs2 is not seen; the old value is used.
- Load port:
  - Active in any state.
  - A write collision with writeback (same edge, same address): writeback wins.
  - Different addresses: both writes happen.
- alu_s/alu_a/alu_b hold their last values outside ISSUE.
- Arithmetic (performed entirely by the ALU; this block never computes):
  - SUB: A-B via two's complement; Co=1 means no borrow.
  - AND/OR: Co=0 is captured as-is.
- Wrap-around: results are DW bits; overflow is visible only via carry.
- rd may equal rs1 or rs2; the source operands are already latched.
- req_valid outside IDLE is ignored. The requester must hold req_valid until it sees req_ready=1.

Optional Feature:
- Macro ALU_SEQ_ZERO_FLAG_EN.
- When defined:
  - Extra output port `zero` (1 bit), registered with result, equal to (alu_c==0).
  - Resets to 1.
  - Updated only at writeback.
- When undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg:
  - Op encodings OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11.
  - DW, NREG and register-address width constants.
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, WB=2'd2.
- One sub-module, alu_seq_regfile:
  - 2 write ports, writeback priority over load.
  - 3 combinational read ports: rs1, rs2, dbg.
  - Asynchronous active-low reset.
- FSM and ALU-port registers stay in the top.

Test Plan:
- Reset, then dbg read of all 4 registers -> each 0; req_ready=1, done=0, carry=0.
- Load r0=4'h7, r1=4'h9; ADD rd=2 rs1=0 rs2=1 -> alu_s=00 during ISSUE; done 2 cycles after acceptance; result=4'h0, carry=1, r2=0 (and zero=1 with ALU_SEQ_ZERO_FLAG_EN).
- Load r0=4'h3, r1=4'h5; SUB rd=3 rs1=0 rs2=1 -> r3=4'hE, carry=0 (borrow); then AND rd=1 rs1=3 rs2=1 -> r1=4'h4, carry=0.
- Issue OR rd=0 rs1=0 rs2=0 (r0=4'hA) with ld_en to addr 0, data 4'h5 on the writeback edge -> r0=4'hA (writeback wins); then hold req_valid high continuously -> acceptances exactly 3 cycles apart.
- Accept a request, assert rst_n=0 during ISSUE -> no done pulse; all registers 0; req_ready=1 immediately after reset release.
- ld_en to r1 in the acceptance cycle of ADD rd=2 rs1=1 rs2=1 (old r1=4'h2, new 4'h6) -> alu_a=alu_b=4'h2, r2=4'h4, r1=4'h6.
